// File: rtl/julia_pkg.sv
// Shared fixed-point constants and scan-state encoding for the Julia set datapath.
package julia_pkg;

    localparam int FP_W = 32;
    localparam int FRAC = 28;

    // Q4.28 defaults: view spans re [-2.0, 2.0) and im (-1.5, 1.5]
    localparam logic [FP_W-1:0] RE_MIN_DEF = 32'hE0000000;
    localparam logic [FP_W-1:0] IM_MAX_DEF = 32'h18000000;
    localparam logic [FP_W-1:0] STEP_DEF   = 32'h0019999A;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_WRITE   = 3'd4,
        S_ADVANCE = 3'd5,
        S_DONE    = 3'd6
    } scan_state_t;

endpackage

// File: rtl/julia_coord_gen.sv
// Raster-order pixel walker: x/y counters, re/im accumulators and linear frame-buffer address.
module julia_coord_gen
    import julia_pkg::*;
#(
    parameter int              H_RES  = 640,
    parameter int              V_RES  = 480,
    parameter int              ADDR_W = 19,
    parameter logic [FP_W-1:0] RE_MIN = RE_MIN_DEF,
    parameter logic [FP_W-1:0] IM_MAX = IM_MAX_DEF,
    parameter logic [FP_W-1:0] STEP   = STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              step,
    output logic [FP_W-1:0]   z_re,
    output logic [FP_W-1:0]   z_im,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              last_pix
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [FP_W-1:0]   r_re;
    logic [FP_W-1:0]   r_im;
    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_re   <= '0;
            r_im   <= '0;
            r_addr <= '0;
        end else if (init) begin
            r_x    <= '0;
            r_y    <= '0;
            r_re   <= RE_MIN;
            r_im   <= IM_MAX;
            r_addr <= '0;
        end else if (step) begin
            // Address is a running counter, so it never needs y*H_RES
            r_addr <= r_addr + ADDR_W'(1);
            if (last_col) begin
                r_x  <= '0;
                r_re <= RE_MIN;
                r_y  <= r_y + YW'(1);
                r_im <= r_im - STEP;
            end else begin
                r_x  <= r_x + XW'(1);
                r_re <= r_re + STEP;
            end
        end
    end

    assign last_col = (r_x == X_LAST);
    assign last_pix = last_col && (r_y == Y_LAST);
    assign z_re     = r_re;
    assign z_im     = r_im;
    assign addr     = r_addr;

endmodule

// File: rtl/julia_scan_ctrl.sv
// Frame scheduler: captures C, walks every pixel, runs the iteration engine once per pixel
// and writes the saturated escape count to the frame buffer.
module julia_scan_ctrl
    import julia_pkg::*;
#(
    parameter int              H_RES    = 640,
    parameter int              V_RES    = 480,
    parameter int              ADDR_W   = 19,
    parameter int              CNT_W    = 8,
    parameter int              MAX_ITER = 255,
    parameter logic [FP_W-1:0] RE_MIN   = RE_MIN_DEF,
    parameter logic [FP_W-1:0] IM_MAX   = IM_MAX_DEF,
    parameter logic [FP_W-1:0] STEP     = STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_done,
    input  logic [FP_W-1:0]   c_re_in,
    input  logic [FP_W-1:0]   c_im_in,
    input  logic              restart,
    input  logic              eng_ready,
    output logic              eng_start,
    output logic [FP_W-1:0]   eng_z_re,
    output logic [FP_W-1:0]   eng_z_im,
    output logic [FP_W-1:0]   eng_c_re,
    output logic [FP_W-1:0]   eng_c_im,
    input  logic              eng_done,
    input  logic [CNT_W-1:0]  eng_iter,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [CNT_W-1:0]  fb_data,
    output logic              busy,
    output logic              frame_done,
    output scan_state_t       dbg_state
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    // Engine handshake: eng_start is a single-cycle pulse issued only when ISSUE sees
    // eng_ready high; eng_done is honoured only in WAIT and eng_ready only in ISSUE.
    scan_state_t      r_state;
    scan_state_t      w_next;
    logic             w_init;
    logic             w_step;
    logic             w_last_col;
    logic             w_last_pix;
    logic             r_eng_start;
    logic [FP_W-1:0]  r_c_re;
    logic [FP_W-1:0]  r_c_im;
    logic [CNT_W-1:0] r_fb_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_init = 1'b0;
        w_step = 1'b0;
        case (r_state)
            S_IDLE:    if (cfg_done) w_next = S_LOAD;
            S_LOAD: begin
                w_init = 1'b1;
                w_next = S_ISSUE;
            end
            S_ISSUE:   if (eng_ready) w_next = S_WAIT;
            S_WAIT:    if (eng_done) w_next = S_WRITE;
            S_WRITE:   w_next = S_ADVANCE;
            S_ADVANCE: begin
                if (w_last_pix) begin
                    w_next = S_DONE;
                end else begin
                    w_step = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            S_DONE:    if (restart) w_next = S_LOAD;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_eng_start <= 1'b0;
            r_c_re      <= '0;
            r_c_im      <= '0;
            r_fb_data   <= '0;
        end else begin
            r_eng_start <= (r_state == S_ISSUE) && eng_ready;
            if (r_state == S_LOAD) begin
                r_c_re <= c_re_in;
                r_c_im <= c_im_in;
            end
            if ((r_state == S_WAIT) && eng_done)
                r_fb_data <= (eng_iter > MAX_CNT) ? MAX_CNT : eng_iter;
        end
    end

    julia_coord_gen #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W),
        .RE_MIN (RE_MIN),
        .IM_MAX (IM_MAX),
        .STEP   (STEP)
    ) u_coord (
        .clk      (clk),
        .rst      (rst),
        .init     (w_init),
        .step     (w_step),
        .z_re     (eng_z_re),
        .z_im     (eng_z_im),
        .addr     (fb_addr),
        .last_col (w_last_col),
        .last_pix (w_last_pix)
    );

    assign eng_start  = r_eng_start;
    assign eng_c_re   = r_c_re;
    assign eng_c_im   = r_c_im;
    assign fb_data    = r_fb_data;
    assign fb_we      = (r_state == S_WRITE);
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign frame_done = (r_state == S_DONE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_julia_scan_ctrl.sv
// Directed bench for julia_scan_ctrl on a 4x3 frame with unit (1.0) pixel step.
module tb_julia_scan_ctrl;
    import julia_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_done;
    logic [31:0] c_re_in;
    logic [31:0] c_im_in;
    logic        restart;
    logic        eng_ready;
    logic        eng_start;
    logic [31:0] eng_z_re;
    logic [31:0] eng_z_im;
    logic [31:0] eng_c_re;
    logic [31:0] eng_c_im;
    logic        eng_done;
    logic [8:0]  eng_iter;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [8:0]  fb_data;
    logic        busy;
    logic        frame_done;
    scan_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] p_zre;
    logic [31:0] p_zim;
    logic [18:0] p_addr;
    logic [8:0]  p_data;
    bit          p_ok;

    julia_scan_ctrl #(
        .H_RES    (4),
        .V_RES    (3),
        .ADDR_W   (19),
        .CNT_W    (9),
        .MAX_ITER (255),
        .RE_MIN   (32'hE0000000),
        .IM_MAX   (32'h18000000),
        .STEP     (32'h10000000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_done   (cfg_done),
        .c_re_in    (c_re_in),
        .c_im_in    (c_im_in),
        .restart    (restart),
        .eng_ready  (eng_ready),
        .eng_start  (eng_start),
        .eng_z_re   (eng_z_re),
        .eng_z_im   (eng_z_im),
        .eng_c_re   (eng_c_re),
        .eng_c_im   (eng_c_im),
        .eng_done   (eng_done),
        .eng_iter   (eng_iter),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .busy       (busy),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Engine model for one pixel: accept start, answer one cycle later, collect the write.
    task automatic serve_pixel(input logic [8:0] iter, output logic [31:0] zre,
                               output logic [31:0] zim, output logic [18:0] addr,
                               output logic [8:0] data, output bit ok);
        int i;
        ok = 0; zre = '0; zim = '0; addr = '0; data = '0;
        eng_ready = 1'b1;
        i = 0;
        while (eng_start !== 1'b1 && i < 60) begin @(negedge clk); i++; end
        if (eng_start !== 1'b1) begin
            eng_ready = 1'b0;
            return;
        end
        zre = eng_z_re;
        zim = eng_z_im;
        eng_ready = 1'b0;
        @(negedge clk);
        eng_iter = iter;
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        eng_iter = '0;
        i = 0;
        while (fb_we !== 1'b1 && i < 5) begin @(negedge clk); i++; end
        if (fb_we !== 1'b1) return;
        addr = fb_addr;
        data = fb_data;
        ok = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [159:0] all_out;
        rst = 1'b0; cfg_done = 1'b0; c_re_in = '0; c_im_in = '0; restart = 1'b0;
        eng_ready = 1'b0; eng_done = 1'b0; eng_iter = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            all_out = {eng_start, fb_we, busy, frame_done, fb_addr, fb_data,
                       eng_z_re, eng_z_im, eng_c_re, eng_c_im};
            n_checks++;
            if (all_out !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", k, all_out);
            end
        end
        n_checks++;
        if (dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
        end
    endtask

    task automatic test_first_pixel();
        c_re_in = 32'h01000000;
        c_im_in = 32'h02000000;
        cfg_done = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_busy: got %b expected 1", busy);
        end
        serve_pixel(9'd0, p_zre, p_zim, p_addr, p_data, p_ok);
        cfg_done = 1'b0;
        c_re_in = 32'hDEADBEEF;
        c_im_in = 32'hCAFEF00D;
        n_checks++;
        if (p_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL first_handshake: got %b expected 1", p_ok);
        end
        n_checks++;
        if ({eng_c_re, eng_c_im} !== {32'h01000000, 32'h02000000}) begin
            n_fail++;
            $display("FAIL c_capture: got %h %h expected 01000000 02000000", eng_c_re, eng_c_im);
        end
        n_checks++;
        if ({p_zre, p_zim} !== {32'hE0000000, 32'h18000000}) begin
            n_fail++;
            $display("FAIL first_z0: got %h %h expected e0000000 18000000", p_zre, p_zim);
        end
        n_checks++;
        if ({p_addr, p_data} !== {19'd0, 9'd0}) begin
            n_fail++;
            $display("FAIL first_write: got addr %0d data %0d expected 0 0", p_addr, p_data);
        end
    endtask

    task automatic test_stall_and_stray();
        eng_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 5) begin
                eng_iter = 9'd77;
                eng_done = 1'b1;
            end
            @(negedge clk);
            eng_done = 1'b0;
            n_checks++;
            if ({eng_start, fb_we, busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL stall_cycle %0d: start/we/busy got %b expected 001",
                         k, {eng_start, fb_we, busy});
            end
        end
        serve_pixel(9'd1, p_zre, p_zim, p_addr, p_data, p_ok);
        n_checks++;
        if ({p_ok, p_addr, p_data} !== {1'b1, 19'd1, 9'd1}) begin
            n_fail++;
            $display("FAIL after_stall: got ok %b addr %0d data %0d expected 1 1 1",
                     p_ok, p_addr, p_data);
        end
    endtask

    task automatic test_saturation();
        serve_pixel(9'd300, p_zre, p_zim, p_addr, p_data, p_ok);
        n_checks++;
        if ({p_ok, p_addr, p_data} !== {1'b1, 19'd2, 9'd255}) begin
            n_fail++;
            $display("FAIL saturate: got ok %b addr %0d data %0d expected 1 2 255",
                     p_ok, p_addr, p_data);
        end
    endtask

    task automatic test_full_frame();
        logic [31:0] exp_re;
        logic [31:0] exp_im;
        int i;
        for (int p = 3; p < 12; p++) begin
            serve_pixel(9'(p), p_zre, p_zim, p_addr, p_data, p_ok);
            exp_re = 32'hE0000000 + 32'(p % 4) * 32'h10000000;
            exp_im = 32'h18000000 - 32'(p / 4) * 32'h10000000;
            n_checks++;
            if ({p_ok, p_addr, p_data} !== {1'b1, 19'(p), 9'(p)}) begin
                n_fail++;
                $display("FAIL frame_write px %0d: got ok %b addr %0d data %0d expected 1 %0d %0d",
                         p, p_ok, p_addr, p_data, p, p);
            end
            n_checks++;
            if ({p_zre, p_zim} !== {exp_re, exp_im}) begin
                n_fail++;
                $display("FAIL frame_z0 px %0d: got %h %h expected %h %h",
                         p, p_zre, p_zim, exp_re, exp_im);
            end
        end
        n_checks++;
        if (eng_c_re !== 32'h01000000) begin
            n_fail++;
            $display("FAIL c_held: got %h expected 01000000", eng_c_re);
        end
        i = 0;
        while (frame_done !== 1'b1 && i < 10) begin @(negedge clk); i++; end
        n_checks++;
        if ({frame_done, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL frame_done: got done/busy %b expected 10", {frame_done, busy});
        end
        n_checks++;
        if ({fb_addr, eng_z_re, eng_z_im} !== {19'd11, 32'h10000000, 32'hF8000000}) begin
            n_fail++;
            $display("FAIL done_hold: got addr %0d z %h %h expected 11 10000000 f8000000",
                     fb_addr, eng_z_re, eng_z_im);
        end
        eng_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({eng_start, fb_we, frame_done} !== 3'b001) begin
                n_fail++;
                $display("FAIL done_idle cycle %0d: start/we/done got %b expected 001",
                         k, {eng_start, fb_we, frame_done});
            end
        end
        eng_ready = 1'b0;
    endtask

    task automatic test_restart();
        c_re_in = 32'h0A000000;
        c_im_in = 32'hF5000000;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        serve_pixel(9'd0, p_zre, p_zim, p_addr, p_data, p_ok);
        n_checks++;
        if ({eng_c_re, eng_c_im} !== {32'h0A000000, 32'hF5000000}) begin
            n_fail++;
            $display("FAIL restart_c: got %h %h expected 0a000000 f5000000", eng_c_re, eng_c_im);
        end
        n_checks++;
        if ({p_ok, p_addr, p_zre, p_zim} !== {1'b1, 19'd0, 32'hE0000000, 32'h18000000}) begin
            n_fail++;
            $display("FAIL restart_origin: got ok %b addr %0d z %h %h expected 1 0 e0000000 18000000",
                     p_ok, p_addr, p_zre, p_zim);
        end
    endtask

    task automatic test_reset_midscan();
        logic [159:0] all_out;
        int i;
        for (int p = 1; p < 5; p++) begin
            serve_pixel(9'(p), p_zre, p_zim, p_addr, p_data, p_ok);
            n_checks++;
            if ({p_ok, p_addr} !== {1'b1, 19'(p)}) begin
                n_fail++;
                $display("FAIL rescan px %0d: got ok %b addr %0d expected 1 %0d", p, p_ok, p_addr, p);
            end
        end
        eng_ready = 1'b1;
        i = 0;
        while (eng_start !== 1'b1 && i < 20) begin @(negedge clk); i++; end
        eng_ready = 1'b0;
        n_checks++;
        if ({eng_start, fb_addr} !== {1'b1, 19'd5}) begin
            n_fail++;
            $display("FAIL px5_start: got start %b addr %0d expected 1 5", eng_start, fb_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        all_out = {eng_start, fb_we, busy, frame_done, fb_addr, fb_data,
                   eng_z_re, eng_z_im, eng_c_re, eng_c_im};
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", all_out);
        end
        eng_iter = 9'd5;
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        n_checks++;
        if (fb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_write: got %b expected 0", fb_we);
        end
        cfg_done = 1'b1;
        rst = 1'b1;
        serve_pixel(9'd0, p_zre, p_zim, p_addr, p_data, p_ok);
        n_checks++;
        if ({p_ok, p_addr, p_zre, p_zim} !== {1'b1, 19'd0, 32'hE0000000, 32'h18000000}) begin
            n_fail++;
            $display("FAIL post_reset_scan: got ok %b addr %0d z %h %h expected 1 0 e0000000 18000000",
                     p_ok, p_addr, p_zre, p_zim);
        end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_stall_and_stray();
        test_saturation();
        test_full_frame();
        test_restart();
        test_reset_midscan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
